execute_stage_mc: RTL
=====================

Name: execute_stage_mc

Overview:
Parametrised next-generation execute stage for the RV32IMFA pipeline. Single-cycle ops use the integer ALU. Multi-cycle ops (FPU, MUL/DIV) are issued to an external unit over a start/done handshake. Operands are captured at issue, so forwarding sources may change during the stall. Results go to a registered EX/MEM output with a valid bit, and the block stalls upstream while a multi-cycle op is in flight or MEM back-pressures.

Parameters:
XLEN, 32, datapath width for integer and FP bit-patterns.
REG_AW, 5, register index width.
MC_TIMEOUT, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
in_Clk  input  1  clock
in_Rst_N  input  1  asynchronous active-low reset
in_valid  input  1  ID/EX entry valid
in_flush  input  1  kill the current EX op and any in-flight MC op
in_mem_stall  input  1  MEM cannot accept this cycle
in_RegWrite, in_MemWrite, in_ResultSrc, in_Branch, in_ALUSrc, in_isMC, in_isFP  input  1 each  decoded controls
in_ALUControl  input  5  integer ALU op
in_MCControl  input  5  multi-cycle unit op
in_RD1, in_RD2, in_FPRD1, in_FPRD2, in_Imm, in_PC  input  XLEN each  operands
in_Rd  input  REG_AW  destination register
in_FwdM, in_FwdW, in_FPFwdM, in_FPFwdW  input  XLEN each  forwarded values
in_FwdA, in_FwdB, in_FPFwdA, in_FPFwdB  input  2 each  select: 00 register file, 01 WB, 10 MEM, 11 treated as 00
out_mc_start  output  1  one-cycle issue pulse
out_mc_op  output  5  captured op
out_mc_a, out_mc_b  output  XLEN each  captured operands
in_mc_done  input  1  result valid, one cycle
in_mc_result  input  XLEN  MC result
out_stall  output  1  freeze IF/ID and ID/EX
out_PCSrc  output  1  branch taken (combinational)
out_PCTarget  output  XLEN  in_PC + in_Imm
out_valid, out_RegWrite, out_MemWrite, out_ResultSrc, out_isFP  output  1 each  EX/MEM register
out_Result, out_WriteData  output  XLEN each  EX/MEM data
out_Rd  output  REG_AW  EX/MEM destination register

Behaviour:
- Reset (async, in_Rst_N=0): FSM to IDLE; all outputs 0, including out_valid, out_mc_start and every EX/MEM field.
- Forwarding: integer and FP selects are independent. Integer operand B = in_ALUSrc ? in_Imm : forwarded B. out_WriteData = forwarded B, never the immediate.
- FSM states:
  - IDLE
    - in_valid & !in_isMC & !in_mem_stall: load EX/MEM with the ALU result at the next edge (latency 1), out_valid=1.
    - in_valid & in_isMC: capture op and FP or integer operands (in_isFP selects which), go to ISSUE; out_stall=1.
    - out_PCSrc = in_valid & in_Branch & ALU zero; asserted only in IDLE.
  - ISSUE: out_mc_start=1 for exactly one cycle -> WAIT.
  - WAIT: on in_mc_done, latch in_mc_result.
    - !in_mem_stall: write EX/MEM, out_valid=1 -> IDLE.
    - in_mem_stall: -> HOLD.
  - HOLD: keep the result until !in_mem_stall, then write EX/MEM -> IDLE.
- out_stall = (state!=IDLE) | (in_valid & in_isMC) | in_mem_stall, but deasserts in the cycle the EX/MEM write from WAIT or HOLD occurs.
- in_mem_stall in IDLE: EX/MEM holds its contents, including out_valid.
- If not stalled and !in_valid, out_valid=0 at the next edge (bubble).
- in_flush has priority over everything:
  - FSM -> IDLE, out_valid=0 at the next edge, out_PCSrc=0.
  - A later in_mc_done for the killed op is ignored.
  - A flush in the same cycle as in_mc_done discards the result.
- Back-to-back MC ops: the second op issues only after the first has been written to EX/MEM. There is no overlap.
- in_mc_done outside WAIT is ignored.
- The FP result is written to out_Result with out_isFP=1. Integer compare FP ops set out_isFP=0 per decode.

Optional Feature:
MC_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT. If it reaches MC_TIMEOUT without in_mc_done, the FSM aborts to IDLE and writes EX/MEM with out_valid=1, out_RegWrite=0, out_MemWrite=0 (a harmless bubble). A sticky output out_mc_err (1 bit, cleared only by reset) is set.
  - The counter resets on each ISSUE.
- Undefined: no counter; out_mc_err is absent; WAIT waits indefinitely.

Decomposition:
- Shared package exe_pkg holds:
  - forwarding select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - FSM state encoding IDLE/ISSUE/WAIT/HOLD;
  - the XLEN default.
- One natural sub-module, exe_fwd_mux: a 3:1 forwarding mux instantiated four times.
- The existing ALU is instantiated unchanged.

Test Plan:
- ADD, in_RD1=5, in_RD2=7, forwards 00 -> out_Result=12, out_valid=1 one cycle later, out_stall never asserted.
- in_FwdA=10, in_FwdM=100, ALUSrc=1, in_Imm=-4 -> out_Result=96; out_WriteData=in_RD2.
- FADD issue; forwarding inputs changed in the cycle after issue -> out_mc_a/out_mc_b hold the issue-time values; out_mc_start high exactly one cycle; in_mc_done 5 cycles later with result 0x40400000 -> out_Result=0x40400000, out_isFP=1.
- in_mc_done with in_mem_stall=1 for 3 cycles -> HOLD; out_stall=1; EX/MEM written on the first cycle in_mem_stall=0.
- BEQ with equal operands, in_Imm=16, in_PC=0x100 -> out_PCSrc=1, out_PCTarget=0x110; same with in_flush=1 -> out_PCSrc=0.
- Flush during WAIT, then a late in_mc_done -> ignored, out_valid=0; with MC_TIMEOUT_EN, no done for 64 cycles -> out_mc_err=1 and a bubble is written.

Source files
------------

// File: rtl/exe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exe_pkg
// Description : Shared definitions for the multi-cycle execute stage:
//               forwarding select codes, FSM state encoding, integer ALU
//               op codes and the default datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package exe_pkg;

  localparam int XLEN_DEF = 32;

  // Forwarding selects; 2'b11 is decoded as register file.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } exe_state_t;

  // Integer ALU op codes (in_ALUControl).
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLT  = 5'd5;
  localparam logic [4:0] ALU_SLTU = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_SRA  = 5'd9;

endpackage
`default_nettype wire

// File: rtl/exe_alu.sv
`default_nettype none
// ============================================================================
// Module      : exe_alu
// Description : Single-cycle integer ALU of the RV32 pipeline.
// Ports       : in_SrcA, in_SrcB  - operands
//               in_ALUControl     - op code (ALU_* in exe_pkg)
//               out_Result        - result
//               out_Zero          - result equals zero (branch compare)
// Revision    : 1.0 - initial release
// ============================================================================
module exe_alu
  import exe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] in_SrcA,
  input  logic [XLEN-1:0] in_SrcB,
  input  logic [4:0]      in_ALUControl,
  output logic [XLEN-1:0] out_Result,
  output logic            out_Zero
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = in_SrcB[SHW-1:0];

  always_comb begin
    out_Result = in_SrcA + in_SrcB;
    case (in_ALUControl)
      ALU_ADD:  out_Result = in_SrcA + in_SrcB;
      ALU_SUB:  out_Result = in_SrcA - in_SrcB;
      ALU_AND:  out_Result = in_SrcA & in_SrcB;
      ALU_OR:   out_Result = in_SrcA | in_SrcB;
      ALU_XOR:  out_Result = in_SrcA ^ in_SrcB;
      ALU_SLT:  out_Result = {{(XLEN-1){1'b0}}, $signed(in_SrcA) < $signed(in_SrcB)};
      ALU_SLTU: out_Result = {{(XLEN-1){1'b0}}, in_SrcA < in_SrcB};
      ALU_SLL:  out_Result = in_SrcA << w_shamt;
      ALU_SRL:  out_Result = in_SrcA >> w_shamt;
      ALU_SRA:  out_Result = XLEN'($signed(in_SrcA) >>> w_shamt);
      default:  out_Result = in_SrcA + in_SrcB;
    endcase
  end

  assign out_Zero = (out_Result == '0);

endmodule
`default_nettype wire

// File: rtl/exe_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : exe_fwd_mux
// Description : 3:1 operand forwarding mux (register file / WB / MEM).
// Ports       : in_sel  - forwarding select (00 RF, 01 WB, 10 MEM, 11 RF)
//               in_rf, in_wb, in_mem - candidate values
//               out_val - selected operand
// Revision    : 1.0 - initial release
// ============================================================================
module exe_fwd_mux
  import exe_pkg::*;
#(
  parameter int W = XLEN_DEF
) (
  input  logic [1:0]   in_sel,
  input  logic [W-1:0] in_rf,
  input  logic [W-1:0] in_wb,
  input  logic [W-1:0] in_mem,
  output logic [W-1:0] out_val
);

  always_comb begin
    out_val = in_rf;
    case (in_sel)
      FWD_WB:  out_val = in_wb;
      FWD_MEM: out_val = in_mem;
      default: out_val = in_rf;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/execute_stage_mc.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_mc
// Description : Execute stage with single-cycle integer ALU and a start/done
//               handshake to an external multi-cycle unit (FPU, MUL/DIV).
//               Operands are captured at issue; results land in a registered
//               EX/MEM stage. Upstream is stalled while an MC op is in flight
//               or MEM back-pressures.
// Options     : `define MC_TIMEOUT_EN adds a WAIT watchdog (MC_TIMEOUT cycles)
//               and the sticky out_mc_err output.
// Ports       : in_Clk/in_Rst_N  - clock, async active-low reset
//               in_valid/in_flush/in_mem_stall - pipeline control
//               in_* controls, operands, forwarding values/selects
//               out_mc_* / in_mc_* - multi-cycle unit handshake
//               out_stall, out_PCSrc, out_PCTarget - to front end
//               out_valid .. out_Rd - EX/MEM register
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage_mc
  import exe_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_AW     = 5,
  parameter int MC_TIMEOUT = 64
) (
  input  logic              in_Clk,
  input  logic              in_Rst_N,
  input  logic              in_valid,
  input  logic              in_flush,
  input  logic              in_mem_stall,
  input  logic              in_RegWrite,
  input  logic              in_MemWrite,
  input  logic              in_ResultSrc,
  input  logic              in_Branch,
  input  logic              in_ALUSrc,
  input  logic              in_isMC,
  input  logic              in_isFP,
  input  logic [4:0]        in_ALUControl,
  input  logic [4:0]        in_MCControl,
  input  logic [XLEN-1:0]   in_RD1,
  input  logic [XLEN-1:0]   in_RD2,
  input  logic [XLEN-1:0]   in_FPRD1,
  input  logic [XLEN-1:0]   in_FPRD2,
  input  logic [XLEN-1:0]   in_Imm,
  input  logic [XLEN-1:0]   in_PC,
  input  logic [REG_AW-1:0] in_Rd,
  input  logic [XLEN-1:0]   in_FwdM,
  input  logic [XLEN-1:0]   in_FwdW,
  input  logic [XLEN-1:0]   in_FPFwdM,
  input  logic [XLEN-1:0]   in_FPFwdW,
  input  logic [1:0]        in_FwdA,
  input  logic [1:0]        in_FwdB,
  input  logic [1:0]        in_FPFwdA,
  input  logic [1:0]        in_FPFwdB,
  output logic              out_mc_start,
  output logic [4:0]        out_mc_op,
  output logic [XLEN-1:0]   out_mc_a,
  output logic [XLEN-1:0]   out_mc_b,
  input  logic              in_mc_done,
  input  logic [XLEN-1:0]   in_mc_result,
  output logic              out_stall,
  output logic              out_PCSrc,
  output logic [XLEN-1:0]   out_PCTarget,
  output logic              out_valid,
  output logic              out_RegWrite,
  output logic              out_MemWrite,
  output logic              out_ResultSrc,
  output logic              out_isFP,
  output logic [XLEN-1:0]   out_Result,
  output logic [XLEN-1:0]   out_WriteData,
`ifdef MC_TIMEOUT_EN
  output logic              out_mc_err,
`endif
  output logic [REG_AW-1:0] out_Rd
);

  if (MC_TIMEOUT < 2) begin : g_timeout_check
    $error("MC_TIMEOUT must be at least 2");
  end

  // ---------------------------------------------------------------- operands
  logic [XLEN-1:0] w_int_a, w_int_b, w_fp_a, w_fp_b, w_alu_b, w_alu_res;
  logic            w_zero;

  exe_fwd_mux #(.W(XLEN)) u_fwd_a (
    .in_sel(in_FwdA), .in_rf(in_RD1), .in_wb(in_FwdW), .in_mem(in_FwdM), .out_val(w_int_a));
  exe_fwd_mux #(.W(XLEN)) u_fwd_b (
    .in_sel(in_FwdB), .in_rf(in_RD2), .in_wb(in_FwdW), .in_mem(in_FwdM), .out_val(w_int_b));
  exe_fwd_mux #(.W(XLEN)) u_fpfwd_a (
    .in_sel(in_FPFwdA), .in_rf(in_FPRD1), .in_wb(in_FPFwdW), .in_mem(in_FPFwdM), .out_val(w_fp_a));
  exe_fwd_mux #(.W(XLEN)) u_fpfwd_b (
    .in_sel(in_FPFwdB), .in_rf(in_FPRD2), .in_wb(in_FPFwdW), .in_mem(in_FPFwdM), .out_val(w_fp_b));

  assign w_alu_b = in_ALUSrc ? in_Imm : w_int_b;

  exe_alu #(.XLEN(XLEN)) u_alu (
    .in_SrcA(w_int_a), .in_SrcB(w_alu_b), .in_ALUControl(in_ALUControl),
    .out_Result(w_alu_res), .out_Zero(w_zero));

  // ---------------------------------------------------------------- FSM
  exe_state_t r_state, w_next;
  logic       w_capture;   // IDLE accepts an MC op this cycle
  logic       w_mc_write;  // MC result goes into EX/MEM this cycle
  logic       w_mc_abort;  // watchdog bubble goes into EX/MEM this cycle
  logic       w_timeout;

`ifdef MC_TIMEOUT_EN
  localparam int CW = $clog2(MC_TIMEOUT + 1);
  logic [CW-1:0] r_to_cnt;
  logic          r_mc_err;

  assign w_timeout  = (r_state == WAIT) && (r_to_cnt == CW'(MC_TIMEOUT - 1));
  assign out_mc_err = r_mc_err;

  // Counter holds at the limit if MEM back-pressure delays the abort write.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      r_to_cnt <= '0;
      r_mc_err <= 1'b0;
    end else begin
      if (r_state == ISSUE)
        r_to_cnt <= '0;
      else if (r_state == WAIT && !w_timeout)
        r_to_cnt <= r_to_cnt + 1'b1;
      if (w_mc_abort)
        r_mc_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_mc_write = 1'b0;
    w_mc_abort = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && in_isMC) begin
          w_capture = 1'b1;
          w_next    = ISSUE;
        end
      end
      ISSUE: w_next = WAIT;
      WAIT: begin
        if (in_mc_done) begin
          if (!in_mem_stall) begin
            w_mc_write = 1'b1;
            w_next     = IDLE;
          end else begin
            w_next = HOLD;
          end
        end else if (w_timeout && !in_mem_stall) begin
          w_mc_abort = 1'b1;
          w_next     = IDLE;
        end
      end
      HOLD: begin
        if (!in_mem_stall) begin
          w_mc_write = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    // Flush kills whatever is in flight, including a same-cycle done.
    if (in_flush) begin
      w_next     = IDLE;
      w_capture  = 1'b0;
      w_mc_write = 1'b0;
      w_mc_abort = 1'b0;
    end
  end

  // ---------------------------------------------------------------- MC capture
  logic [4:0]        r_mc_op;
  logic [XLEN-1:0]   r_mc_a, r_mc_b, r_mc_wd, r_mc_res;
  logic [REG_AW-1:0] r_mc_rd;
  logic              r_mc_regwrite, r_mc_memwrite, r_mc_resultsrc, r_mc_isfp;

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      r_mc_op        <= '0;
      r_mc_a         <= '0;
      r_mc_b         <= '0;
      r_mc_wd        <= '0;
      r_mc_res       <= '0;
      r_mc_rd        <= '0;
      r_mc_regwrite  <= 1'b0;
      r_mc_memwrite  <= 1'b0;
      r_mc_resultsrc <= 1'b0;
      r_mc_isfp      <= 1'b0;
    end else begin
      if (w_capture) begin
        r_mc_op        <= in_MCControl;
        r_mc_a         <= in_isFP ? w_fp_a : w_int_a;
        r_mc_b         <= in_isFP ? w_fp_b : w_int_b;
        r_mc_wd        <= w_int_b;
        r_mc_rd        <= in_Rd;
        r_mc_regwrite  <= in_RegWrite;
        r_mc_memwrite  <= in_MemWrite;
        r_mc_resultsrc <= in_ResultSrc;
        r_mc_isfp      <= in_isFP;
      end
      if (r_state == WAIT && in_mc_done && !in_flush)
        r_mc_res <= in_mc_result;
    end
  end

  assign out_mc_start = (r_state == ISSUE) && !in_flush;
  assign out_mc_op    = r_mc_op;
  assign out_mc_a     = r_mc_a;
  assign out_mc_b     = r_mc_b;

  // ---------------------------------------------------------------- front end
  assign out_PCTarget = in_PC + in_Imm;
  assign out_PCSrc    = (r_state == IDLE) && in_valid && in_Branch && w_zero && !in_flush;
  assign out_stall    = ((r_state != IDLE) || (in_valid && in_isMC) || in_mem_stall)
                        && !(w_mc_write || w_mc_abort);

  // ---------------------------------------------------------------- EX/MEM
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      out_valid     <= 1'b0;
      out_RegWrite  <= 1'b0;
      out_MemWrite  <= 1'b0;
      out_ResultSrc <= 1'b0;
      out_isFP      <= 1'b0;
      out_Result    <= '0;
      out_WriteData <= '0;
      out_Rd        <= '0;
    end else if (in_flush) begin
      out_valid    <= 1'b0;
      out_RegWrite <= 1'b0;
      out_MemWrite <= 1'b0;
    end else if (w_mc_write) begin
      out_valid     <= 1'b1;
      out_RegWrite  <= r_mc_regwrite;
      out_MemWrite  <= r_mc_memwrite;
      out_ResultSrc <= r_mc_resultsrc;
      out_isFP      <= r_mc_isfp;
      out_Result    <= (r_state == HOLD) ? r_mc_res : in_mc_result;
      out_WriteData <= r_mc_wd;
      out_Rd        <= r_mc_rd;
    end else if (w_mc_abort) begin
      // Valid but side-effect free, so MEM/WB simply retire it.
      out_valid     <= 1'b1;
      out_RegWrite  <= 1'b0;
      out_MemWrite  <= 1'b0;
      out_ResultSrc <= 1'b0;
      out_isFP      <= 1'b0;
      out_Result    <= '0;
      out_Rd        <= r_mc_rd;
    end else if (!in_mem_stall) begin
      if (r_state == IDLE && in_valid && !in_isMC) begin
        out_valid     <= 1'b1;
        out_RegWrite  <= in_RegWrite;
        out_MemWrite  <= in_MemWrite;
        out_ResultSrc <= in_ResultSrc;
        out_isFP      <= in_isFP;
        out_Result    <= w_alu_res;
        out_WriteData <= w_int_b;
        out_Rd        <= in_Rd;
      end else begin
        // MEM consumed the previous entry; nothing new from EX this cycle.
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
